// File: rtl/alu_sequencer.sv
// Multi-cycle issue stage for the 8-bit ALU: decode, operand read, execute, writeback, result hand-off.
// Optional retire counter on output retireCount, enabled by defining ALUSEQ_RETIRE_COUNT_EN.
module alu_sequencer #(
  parameter int                   DATA_W    = 8,
  parameter int                   REG_AW    = 3,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              instrValid,
  output logic              instrReady,
  input  logic [11:0]       instr,
  output logic [DATA_W-1:0] aluA,
  output logic [DATA_W-1:0] aluB,
  output logic [2:0]        aluControl,
  input  logic [DATA_W-1:0] aluResult,
  output logic              resValid,
  input  logic              resReady,
  output logic [DATA_W-1:0] resData,
  output logic [REG_AW-1:0] resDest,
  input  logic [REG_AW-1:0] dbgAddr,
  output logic [DATA_W-1:0] dbgData
`ifdef ALUSEQ_RETIRE_COUNT_EN
  ,
  output logic [15:0]       retireCount
`endif
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b011;
  localparam int         NREGS  = 2 ** REG_AW;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t              state, state_nxt;
  logic [2:0]          op_p0;
  logic [REG_AW-1:0]   rd_p0;
  logic [5:0]          imm_p0;
  logic [DATA_W-1:0]   rf [NREGS];
  logic [DATA_W-1:0]   wb_val;
  logic                issue, retire, wr_en;

  // LDI writes the zero-extended immediate; NOP produces zero; everything else takes the ALU output.
  function automatic logic [DATA_W-1:0] wb_select(input logic [2:0]        op,
                                                  input logic [5:0]        imm,
                                                  input logic [DATA_W-1:0] alu);
    logic [DATA_W-1:0] v;
    v = alu;
    if (op == OP_LDI) v = DATA_W'(imm);
    if (op == OP_NOP) v = '0;
    return v;
  endfunction

  assign instrReady = (state == IDLE);
  assign issue      = instrValid && instrReady;
  assign retire     = resValid && resReady;
  assign wr_en      = (state == EXEC) && (op_p0 != OP_NOP);
  assign wb_val     = wb_select(op_p0, imm_p0, aluResult);
  assign dbgData    = rf[dbgAddr];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (issue)  state_nxt = EXEC;
      EXEC:                state_nxt = WB;
      WB:      if (retire) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // issue: latch instruction fields and read operands from the register file
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      op_p0      <= OP_NOP;
      rd_p0      <= '0;
      imm_p0     <= '0;
      aluA       <= '0;
      aluB       <= '0;
      aluControl <= 3'b000;
    end else if (issue) begin
      op_p0      <= instr[11:9];
      rd_p0      <= REG_AW'(instr[8:6]);
      imm_p0     <= instr[5:0];
      aluA       <= rf[REG_AW'(instr[5:3])];
      aluB       <= rf[REG_AW'(instr[2:0])];
      aluControl <= (instr[11:9] == OP_LDI) ? 3'b000 : instr[11:9];
    end else if (retire) begin
      aluControl <= 3'b000;
    end
  end

  // execute: capture the ALU result into the result token
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      resValid <= 1'b0;
      resData  <= '0;
      resDest  <= '0;
    end else if (state == EXEC) begin
      resValid <= 1'b1;
      resData  <= wb_val;
      resDest  <= rd_p0;
    end else if (retire) begin
      resValid <= 1'b0;
    end
  end

  // writeback: register file update lands at the end of EXEC
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= RESET_VAL;
    end else if (wr_en) begin
      rf[rd_p0] <= wb_val;
    end
  end

`ifdef ALUSEQ_RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)     retireCount <= '0;
    else if (retire) retireCount <= retireCount + 16'd1;
  end
`endif

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle issue stage directly upstream of the 8-bit ALU.
- Accepts 12-bit instructions over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU operand and control inputs, captures the ALU result, writes it back, and offers it downstream over a valid/ready handshake.
- One instruction in flight at a time.

Parameters:
- DATA_W, 8, register and ALU datapath width; must match the ALU.
- REG_AW, 3, register-file address width; 2**REG_AW registers.
- RESET_VAL, 0, reset value of every register-file entry.

Ports:
- clk  in  1  rising-edge clock
- resetN  in  1  asynchronous active-low reset
- instrValid  in  1  upstream instruction valid
- instrReady  out  1  sequencer can accept an instruction
- instr  in  12  [11:9] op, [8:6] rd, [5:3] ra, [2:0] rb; for LDI, [5:0] is imm
- aluA  out  DATA_W  ALU operand a
- aluB  out  DATA_W  ALU operand b
- aluControl  out  3  ALU operation select
- aluResult  in  DATA_W  combinational ALU result
- resValid  out  1  result token valid
- resReady  in  1  downstream accepts result
- resData  out  DATA_W  value written, or produced for NOP
- resDest  out  REG_AW  destination register of the token
- dbgAddr  in  REG_AW  debug read address
- dbgData  out  DATA_W  combinational reg[dbgAddr]

Behaviour:
- Reset: asynchronous while resetN=0; all registers reach reset values immediately.
  - State IDLE, instrReady=1.
  - aluA=0, aluB=0, aluControl=3'b000.
  - resValid=0, resData=0, resDest=0.
  - All register-file entries = RESET_VAL.
- FSM states: IDLE, EXEC, WB. All outputs except instrReady and dbgData are registered; instrReady is (state==IDLE).
- IDLE:
  - On instrValid & instrReady at edge N: latch instr.
  - Load aluA=reg[ra], aluB=reg[rb].
  - Load aluControl = (op==3'b011) ? 3'b000 : op.
  - Go to EXEC.
- EXEC (cycle N+1):
  - ALU evaluates combinationally.
  - At edge N+1, select the result: value = zero-extended imm for op 011, else aluResult.
  - Unless op==3'b000, write value to reg[rd].
  - Load resData=value (0 for NOP), resDest=rd, resValid=1.
  - Go to WB.
- WB:
  - Hold resValid, resData and resDest until resValid & resReady at an edge.
  - At that edge: resValid=0, aluControl=3'b000, go to IDLE.
- Latency and throughput:
  - resValid first asserts in cycle N+2.
  - Register writeback becomes visible on dbgData in cycle N+2.
  - With resReady tied high: one instruction every 3 cycles, instrReady high every third cycle.
- Operand hazards: none. Operands are read in IDLE, after the prior writeback completed.
- rd==ra or rd==rb: operands use the old value; the write lands afterwards.
- Undefined ops (001, 100, 110, 111): op is passed to the ALU unchanged and the returned value is written; no error signalled.
- instrValid while not IDLE: ignored; upstream must hold it.
- resReady without resValid: no effect.
- Reset mid-EXEC or mid-WB: the instruction is discarded, no partial write survives, and the state returns to IDLE.
- Wrap-around: arithmetic overflow is the ALU's concern; the sequencer stores the low DATA_W bits only.

Optional Feature:
- Macro: ALUSEQ_RETIRE_COUNT_EN.
- When defined:
  - Adds output retireCount [15:0], reset to 0.
  - Increments by 1 on each resValid & resReady handshake.
  - Wraps 0xFFFF to 0x0000.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- LDI r1, imm=5 (instr=12'h645), resReady=1 -> resValid in cycle N+2 with resData=0x05, resDest=1; dbgAddr=1 gives dbgData=0x05.
- After r1=5, ADD r2=r1+r1 (instr=12'h489), ALU model attached -> aluControl=010, aluA=aluB=0x05 in EXEC; resData=0x0A; reg[2]=0x0A.
- LDI r3=0x3C, then XNOR r4=r3,r1 (instr=12'hB19) -> resData=~(0x3C^0x05)=0xC6.
- Backpressure: hold resReady=0 for 5 cycles after resValid -> resValid, resData and resDest are stable; instrReady=0 throughout; one handshake on release; retireCount advances by exactly 1 when enabled.
- NOP (instr=12'h000) -> resValid with resData=0x00; no register changes; dbgData scan of all 8 registers is unchanged.
- Assert resetN=0 during EXEC of ADD r2 -> immediate IDLE, resValid=0, reg[2]=RESET_VAL, aluControl=000; the next LDI executes normally.
